draw_objects_pipe: RTL and testbench
====================================

Name: draw_objects_pipe

Overview:
Registered, parametrised successor to the combinational Pong object renderer. It takes the pixel coordinate and raw video timing from the VGA timing generator, and decides per pixel whether the pixel is ball, left paddle, right paddle, centre net or background. It outputs RGB with a fixed 2-cycle latency and delays the sync/active signals to match. Object positions are captured once per frame so the picture does not tear, and the ball has an optional blink mode.

Parameters:
ACTIVE_WIDTH, 640, visible pixels per line
ACTIVE_HEIGHT, 480, visible lines per frame
COORD_W, 10, coordinate width in bits
COLOR_W, 4, bits per colour channel
PADDLE_WIDTH, 10, paddle width in pixels
PADDLE_HEIGHT, 50, paddle height in pixels
BALL_SIZE, 10, ball width and height in pixels
NET_EN, 1, 1 = draw the dashed centre net
NET_WIDTH, 2, net width in pixels (must be even)
NET_DASH, 16, dash and gap length in lines (must be a power of two)
BLINK_FRAMES, 8, frames per blink half-period (must be at least 1)
BALL_COLOR, all-ones, {r,g,b}, 3*COLOR_W bits
PADDLE_COLOR, all-ones, {r,g,b}
NET_COLOR, half-intensity grey, {r,g,b}

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
active_in  in  1  pixel is inside the visible area
hsync_in  in  1  raw hsync
vsync_in  in  1  raw vsync
frame_start  in  1  one-cycle pulse, issued before the first active pixel of each frame
ball_x  in  COORD_W  ball left edge
ball_y  in  COORD_W  ball top edge
paddle1_y  in  COORD_W  left paddle top edge
paddle2_y  in  COORD_W  right paddle top edge
ball_blink  in  1  blink mode enable
r  out  COLOR_W  red
g  out  COLOR_W  green
b  out  COLOR_W  blue
active_out  out  1  active_in delayed by 2 cycles
hsync_out  out  1  hsync_in delayed by 2 cycles
vsync_out  out  1  vsync_in delayed by 2 cycles

Behaviour:
- Reset (synchronous, active-high):
  - r, g, b, active_out, hsync_out, vsync_out all 0.
  - Shadow position registers 0; shadow_valid 0.
  - Blink counter 0; blink phase 0.
- Shadow registers: on a clock edge where frame_start=1, ball_x, ball_y, paddle1_y and paddle2_y load into the shadows, and shadow_valid is set to 1.
  - A pixel presented in the same cycle as frame_start is tested against the old shadow values.
- While shadow_valid=0, ball and paddles are never drawn; the net and background still are.
- Stage 1 (registered): compute hit flags ball_hit, p1_hit, p2_hit, net_hit from x and y; register them together with active, hsync and vsync.
- Stage 2 (registered): priority mux onto r, g, b; register the delayed timing signals.
- Latency: an input in cycle N produces its output in cycle N+2.
- Hit tests: half-open intervals [lo, lo+size). Compare at COORD_W+1 bits so that lo+size never wraps.
  - ball: x in [bx, bx+BALL_SIZE) and y in [by, by+BALL_SIZE), gated by ball_visible.
  - p1: x < PADDLE_WIDTH and y in [p1y, p1y+PADDLE_HEIGHT).
  - p2: x in [ACTIVE_WIDTH-PADDLE_WIDTH, ACTIVE_WIDTH) and y in [p2y, p2y+PADDLE_HEIGHT).
  - net: NET_EN, x in [ACTIVE_WIDTH/2-NET_WIDTH/2, ACTIVE_WIDTH/2+NET_WIDTH/2), and the y bit selecting NET_DASH equals 0 (dash on, gap off).
- Priority: ball > p1 > p2 > net > background (0).
- Blanking: if the stage-1 active flag is 0, r, g and b are forced to 0 regardless of hits.
- Blink:
  - ball_blink=0: counter and phase held at 0; ball always visible.
  - ball_blink=1: on each frame_start the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and the phase toggles.
  - ball_visible = ~phase.
  - Phase updates only at frame_start, so visibility never changes mid-frame.
- Reset asserted mid-frame: the pipeline contents are discarded; outputs read 0 on the cycle after the reset edge.

Decomposition:
- pong_pkg holds:
  - the screen constants (ACTIVE_WIDTH, ACTIVE_HEIGHT),
  - the default object sizes,
  - the rgb_t packed type (3*COLOR_W),
  - the default BALL/PADDLE/NET colour constants.
- One sub-module, rect_hit: a combinational half-open rectangle test with a widened compare. It is instantiated three times (ball, p1, p2); the net uses its own inline test.

Test Plan:
- Power-up: hold reset for 3 cycles, release, then drive x=5, y=5, active=1 with ball_x=0, ball_y=0 and no frame_start -> r, g, b = 0 throughout, because shadow_valid=0.
- Latency: frame_start with ball=(100,200), then drive (105,205) active in cycle N -> BALL_COLOR in cycle N+2; (110,205) -> 0; hsync_out and vsync_out equal their inputs delayed by 2 cycles.
- Priority and blanking: ball=(0,20), paddle1_y=20, pixel (5,25) -> BALL_COLOR; pixel (635,25) with paddle2_y=0 -> PADDLE_COLOR; the same pixel with active_in=0 -> 0.
- Tear-free: set ball_x=300 mid-frame -> ball stays at the old position until the next frame_start; a pixel in the frame_start cycle itself uses the old position.
- Edge, no wrap: ball_x=1020, pixel x=2, paddle1_y far away -> 0. Net: pixel (319,5) -> NET_COLOR; (319,20) -> 0; (321,5) -> 0.
- Blink with BLINK_FRAMES=2: ball_blink=1 over 6 frames -> ball visible in frames 1–2, hidden in 3–4, visible in 5–6. Deassert ball_blink -> ball visible from the next frame.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong screen geometry, default object sizes and colour types.
package pong_pkg;

  // Visible screen area of the 640x480 VGA mode
  localparam int PONG_ACTIVE_WIDTH  = 640;
  localparam int PONG_ACTIVE_HEIGHT = 480;
  localparam int PONG_COORD_W       = 10;
  localparam int PONG_COLOR_W       = 4;

  // Default object sizes in pixels / lines
  localparam int PONG_PADDLE_WIDTH  = 10;
  localparam int PONG_PADDLE_HEIGHT = 50;
  localparam int PONG_BALL_SIZE     = 10;
  localparam int PONG_NET_WIDTH     = 2;
  localparam int PONG_NET_DASH      = 16;
  localparam int PONG_BLINK_FRAMES  = 8;

  // Packed {r,g,b} colour word
  typedef logic [3*PONG_COLOR_W-1:0] rgb_t;

  // Default colours: white ball and paddles, half-intensity grey net
  localparam rgb_t BALL_COLOR_DEF   = '1;
  localparam rgb_t PADDLE_COLOR_DEF = '1;
  localparam rgb_t NET_COLOR_DEF    =
    rgb_t'({3{1'b1, {(PONG_COLOR_W-1){1'b0}}}});

  // Per-pixel object hit flags carried from stage 1 to stage 2
  typedef struct packed {
    logic ball;
    logic p1;
    logic p2;
    logic net;
  } hit_flags_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational half-open rectangle test: [lo, lo+size) on both axes.
// Bounds are compared one bit wider than the coordinates so lo+size
// can never wrap around and alias onto small coordinates.
module rect_hit #(
  parameter int COORD_W = 10,
  parameter int SIZE_X  = 10,
  parameter int SIZE_Y  = 10
) (
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [COORD_W-1:0] loX_i,
  input  logic [COORD_W-1:0] loY_i,
  input  logic               en_i,
  output logic               hit_o
);

  localparam logic [COORD_W:0] SX = (COORD_W+1)'(SIZE_X);
  localparam logic [COORD_W:0] SY = (COORD_W+1)'(SIZE_Y);

  logic [COORD_W:0] pxWide;
  logic [COORD_W:0] pyWide;
  logic [COORD_W:0] loXWide;
  logic [COORD_W:0] loYWide;
  logic [COORD_W:0] hiXWide;
  logic [COORD_W:0] hiYWide;

  // Widen operands and form the exclusive upper bounds
  always_comb begin
    pxWide  = {1'b0, px_i};
    pyWide  = {1'b0, py_i};
    loXWide = {1'b0, loX_i};
    loYWide = {1'b0, loY_i};
    hiXWide = loXWide + SX;
    hiYWide = loYWide + SY;
  end

  // Pixel is inside when both axes fall in their half-open spans
  always_comb begin
    hit_o = en_i
          && (pxWide >= loXWide) && (pxWide < hiXWide)
          && (pyWide >= loYWide) && (pyWide < hiYWide);
  end

endmodule

// File: rtl/draw_objects_pipe.sv
// Two-stage registered Pong object renderer. Stage 1 computes the object
// hit flags for the current pixel, stage 2 resolves priority into RGB.
// Object positions are latched once per frame so the picture never tears.
module draw_objects_pipe
  import pong_pkg::*;
#(
  parameter int ACTIVE_WIDTH  = PONG_ACTIVE_WIDTH,
  parameter int ACTIVE_HEIGHT = PONG_ACTIVE_HEIGHT,
  parameter int COORD_W       = PONG_COORD_W,
  parameter int COLOR_W       = PONG_COLOR_W,
  parameter int PADDLE_WIDTH  = PONG_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = PONG_PADDLE_HEIGHT,
  parameter int BALL_SIZE     = PONG_BALL_SIZE,
  parameter bit NET_EN        = 1'b1,
  parameter int NET_WIDTH     = PONG_NET_WIDTH,
  parameter int NET_DASH      = PONG_NET_DASH,
  parameter int BLINK_FRAMES  = PONG_BLINK_FRAMES,
  parameter logic [3*COLOR_W-1:0] BALL_COLOR   = BALL_COLOR_DEF,
  parameter logic [3*COLOR_W-1:0] PADDLE_COLOR = PADDLE_COLOR_DEF,
  parameter logic [3*COLOR_W-1:0] NET_COLOR    = NET_COLOR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               active_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle1_y,
  input  logic [COORD_W-1:0] paddle2_y,
  input  logic               ball_blink,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               active_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [COORD_W-1:0] P1_LEFT = '0;
  localparam logic [COORD_W-1:0] P2_LEFT = COORD_W'(ACTIVE_WIDTH - PADDLE_WIDTH);

  localparam logic [COORD_W:0] NET_LO = (COORD_W+1)'(ACTIVE_WIDTH/2 - NET_WIDTH/2);
  localparam logic [COORD_W:0] NET_HI = (COORD_W+1)'(ACTIVE_WIDTH/2 + NET_WIDTH/2);
  localparam int DASH_BIT = $clog2(NET_DASH);

  // Elaboration-time sanity checks on the geometry parameters
  if (NET_WIDTH % 2 != 0) begin : gNetWidthCheck
    $error("draw_objects_pipe: NET_WIDTH must be even");
  end
  if ((NET_DASH < 1) || ((NET_DASH & (NET_DASH - 1)) != 0)) begin : gNetDashCheck
    $error("draw_objects_pipe: NET_DASH must be a power of two");
  end
  if (DASH_BIT >= COORD_W) begin : gDashBitCheck
    $error("draw_objects_pipe: NET_DASH too large for COORD_W");
  end
  if (BLINK_FRAMES < 1) begin : gBlinkCheck
    $error("draw_objects_pipe: BLINK_FRAMES must be at least 1");
  end
  if ((ACTIVE_WIDTH > (1 << COORD_W)) || (ACTIVE_HEIGHT > (1 << COORD_W))) begin : gScreenCheck
    $error("draw_objects_pipe: screen does not fit in COORD_W bits");
  end

  // ---------------------------------------------------------------------
  // Per-frame shadow copies of the object positions
  // ---------------------------------------------------------------------
  logic [COORD_W-1:0] ballX_q, ballX_d;
  logic [COORD_W-1:0] ballY_q, ballY_d;
  logic [COORD_W-1:0] paddle1Y_q, paddle1Y_d;
  logic [COORD_W-1:0] paddle2Y_q, paddle2Y_d;
  logic               shadowValid_q, shadowValid_d;

  // Load all positions together at frame start, otherwise hold
  always_comb begin
    ballX_d       = ballX_q;
    ballY_d       = ballY_q;
    paddle1Y_d    = paddle1Y_q;
    paddle2Y_d    = paddle2Y_q;
    shadowValid_d = shadowValid_q;
    if (frame_start) begin
      ballX_d       = ball_x;
      ballY_d       = ball_y;
      paddle1Y_d    = paddle1_y;
      paddle2Y_d    = paddle2_y;
      shadowValid_d = 1'b1;
    end
  end

  // Shadow position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ballX_q       <= '0;
      ballY_q       <= '0;
      paddle1Y_q    <= '0;
      paddle2Y_q    <= '0;
      shadowValid_q <= 1'b0;
    end else begin
      ballX_q       <= ballX_d;
      ballY_q       <= ballY_d;
      paddle1Y_q    <= paddle1Y_d;
      paddle2Y_q    <= paddle2Y_d;
      shadowValid_q <= shadowValid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Ball blink: frame counter and visibility phase
  // ---------------------------------------------------------------------
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;
  logic               ballVisible;

  // Step the blink counter only at frame start so visibility is
  // constant across a frame; disabling blink clears it at the next frame
  always_comb begin
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frame_start) begin
      if (!ball_blink) begin
        blinkCnt_d   = '0;
        blinkPhase_d = 1'b0;
      end else if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d   = blinkCnt_q + 1'b1;
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  assign ballVisible = ~blinkPhase_q;

  // ---------------------------------------------------------------------
  // Stage 1: object hit tests
  // ---------------------------------------------------------------------
  logic ballHit;
  logic p1Hit;
  logic p2Hit;
  logic netHit;

  rect_hit #(
    .COORD_W (COORD_W),
    .SIZE_X  (BALL_SIZE),
    .SIZE_Y  (BALL_SIZE)
  ) uBallHit (
    .px_i  (x),
    .py_i  (y),
    .loX_i (ballX_q),
    .loY_i (ballY_q),
    .en_i  (shadowValid_q & ballVisible),
    .hit_o (ballHit)
  );

  rect_hit #(
    .COORD_W (COORD_W),
    .SIZE_X  (PADDLE_WIDTH),
    .SIZE_Y  (PADDLE_HEIGHT)
  ) uP1Hit (
    .px_i  (x),
    .py_i  (y),
    .loX_i (P1_LEFT),
    .loY_i (paddle1Y_q),
    .en_i  (shadowValid_q),
    .hit_o (p1Hit)
  );

  rect_hit #(
    .COORD_W (COORD_W),
    .SIZE_X  (PADDLE_WIDTH),
    .SIZE_Y  (PADDLE_HEIGHT)
  ) uP2Hit (
    .px_i  (x),
    .py_i  (y),
    .loX_i (P2_LEFT),
    .loY_i (paddle2Y_q),
    .en_i  (shadowValid_q),
    .hit_o (p2Hit)
  );

  // Dashed centre net: fixed column span, dash when the dash bit of y is 0
  always_comb begin
    netHit = 1'b0;
    if (NET_EN && ({1'b0, x} >= NET_LO) && ({1'b0, x} < NET_HI)
        && (y[DASH_BIT] == 1'b0)) begin
      netHit = 1'b1;
    end
  end

  hit_flags_t hits_d, hits_q;
  logic       active1_q;
  logic       hsync1_q;
  logic       vsync1_q;

  // Gather the hit flags into one word for the stage-1 register
  always_comb begin
    hits_d      = '0;
    hits_d.ball = ballHit;
    hits_d.p1   = p1Hit;
    hits_d.p2   = p2Hit;
    hits_d.net  = netHit;
  end

  // Stage-1 register: hit flags plus timing delayed by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q    <= '0;
      active1_q <= 1'b0;
      hsync1_q  <= 1'b0;
      vsync1_q  <= 1'b0;
    end else begin
      hits_q    <= hits_d;
      active1_q <= active_in;
      hsync1_q  <= hsync_in;
      vsync1_q  <= vsync_in;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: priority colour mux and output registers
  // ---------------------------------------------------------------------
  logic [3*COLOR_W-1:0] rgb_d, rgb_q;
  logic                 activeOut_q;
  logic                 hsyncOut_q;
  logic                 vsyncOut_q;

  // Ball over left paddle over right paddle over net; blank outside
  // the visible area regardless of hits
  always_comb begin
    rgb_d = '0;
    if (active1_q) begin
      if (hits_q.ball) begin
        rgb_d = BALL_COLOR;
      end else if (hits_q.p1 || hits_q.p2) begin
        rgb_d = PADDLE_COLOR;
      end else if (hits_q.net) begin
        rgb_d = NET_COLOR;
      end
    end
  end

  // Stage-2 register: final colour and timing delayed by two cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= '0;
      activeOut_q <= 1'b0;
      hsyncOut_q  <= 1'b0;
      vsyncOut_q  <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      activeOut_q <= active1_q;
      hsyncOut_q  <= hsync1_q;
      vsyncOut_q  <= vsync1_q;
    end
  end

  assign r          = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign g          = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b          = rgb_q[COLOR_W-1:0];
  assign active_out = activeOut_q;
  assign hsync_out  = hsyncOut_q;
  assign vsync_out  = vsyncOut_q;

endmodule

// File: tb/tb_draw_objects_pipe.sv
// Self-checking bench for draw_objects_pipe: directed scenarios followed by
// randomized traffic, compared against a screen-level reference model.
module tb_draw_objects_pipe;

  localparam int CW = 10;
  localparam int BF = 2;
  localparam logic [11:0] BALL_RGB   = 12'hFFF;
  localparam logic [11:0] PADDLE_RGB = 12'h0F0;
  localparam logic [11:0] NET_RGB    = 12'h888;

  typedef struct packed {
    logic [11:0] rgb;
    logic        act;
    logic        hs;
    logic        vs;
  } obs_t;

  logic          clk;
  logic          reset;
  logic [CW-1:0] x, y;
  logic          activeIn, hsyncIn, vsyncIn, frameStart;
  logic [CW-1:0] ballX, ballY, paddle1Y, paddle2Y;
  logic          ballBlink;
  logic [3:0]    r, g, b;
  logic          activeOut, hsyncOut, vsyncOut;

  int testCount = 0;
  int failCount = 0;

  // Reference model state: what the screen should show this frame
  int mValid, mBx, mBy, mP1, mP2, mBlinkN;
  obs_t expQ[$];

  draw_objects_pipe #(
    .BLINK_FRAMES (BF),
    .PADDLE_COLOR (PADDLE_RGB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .active_in   (activeIn),
    .hsync_in    (hsyncIn),
    .vsync_in    (vsyncIn),
    .frame_start (frameStart),
    .ball_x      (ballX),
    .ball_y      (ballY),
    .paddle1_y   (paddle1Y),
    .paddle2_y   (paddle2Y),
    .ball_blink  (ballBlink),
    .r           (r),
    .g           (g),
    .b           (b),
    .active_out  (activeOut),
    .hsync_out   (hsyncOut),
    .vsync_out   (vsyncOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // Colour the screen should show at (px,py) given this frame's objects
  function automatic logic [11:0] expColor(int px, int py, logic act);
    bit visible;
    visible = ((mBlinkN / BF) % 2) == 0;
    if (!act) return 12'h000;
    if (mValid != 0 && visible && px >= mBx && px < mBx + 10 && py >= mBy && py < mBy + 10)
      return BALL_RGB;
    if (mValid != 0 && px < 10 && py >= mP1 && py < mP1 + 50)
      return PADDLE_RGB;
    if (mValid != 0 && px >= 630 && px < 640 && py >= mP2 && py < mP2 + 50)
      return PADDLE_RGB;
    if (px >= 319 && px < 321 && ((py / 16) % 2) == 0)
      return NET_RGB;
    return 12'h000;
  endfunction

  task automatic checkOutput(string tag, obs_t expected);
    obs_t observed;
    observed.rgb = {r, g, b};
    observed.act = activeOut;
    observed.hs  = hsyncOut;
    observed.vs  = vsyncOut;
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed rgb=%h act/hs/vs=%b%b%b, expected rgb=%h act/hs/vs=%b%b%b",
             tag, observed.rgb, observed.act, observed.hs, observed.vs,
             expected.rgb, expected.act, expected.hs, expected.vs);
    end
  endtask

  task automatic checkColor(string tag, logic [11:0] expected);
    logic [11:0] observed;
    observed = {r, g, b};
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed rgb=%h, expected rgb=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the currently driven inputs; checks the output
  // that belongs to the inputs of two cycles ago
  task automatic applyStimulus();
    obs_t e;
    e.rgb = expColor(int'(x), int'(y), activeIn);
    e.act = activeIn;
    e.hs  = hsyncIn;
    e.vs  = vsyncIn;
    expQ.push_back(e);
    @(posedge clk);
    if (frameStart) begin
      mValid = 1;
      mBx = int'(ballX);
      mBy = int'(ballY);
      mP1 = int'(paddle1Y);
      mP2 = int'(paddle2Y);
      if (ballBlink) mBlinkN++;
      else mBlinkN = 0;
    end
    #1;
    if (expQ.size() == 2) begin
      checkOutput("pipe", expQ[0]);
      void'(expQ.pop_front());
    end
  endtask

  task automatic applyReset(int cycles);
    reset = 1'b1;
    frameStart = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      checkOutput("reset_outputs_zero", '0);
    end
    mValid = 0; mBx = 0; mBy = 0; mP1 = 0; mP2 = 0; mBlinkN = 0;
    expQ.delete();
    expQ.push_back('0);
    reset = 1'b0;
  endtask

  task automatic frameTick();
    frameStart = 1'b1;
    applyStimulus();
    frameStart = 1'b0;
  endtask

  // Present one pixel, then one blank cycle, and check its colour
  task automatic probe(string tag, int px, int py, logic act, logic [11:0] expected);
    x = CW'(px);
    y = CW'(py);
    activeIn = act;
    applyStimulus();
    activeIn = 1'b0;
    applyStimulus();
    checkColor(tag, expected);
  endtask

  initial begin
    logic [5:0] visPattern;
    reset = 1'b1; x = '0; y = '0; activeIn = 1'b0; hsyncIn = 1'b0; vsyncIn = 1'b0;
    frameStart = 1'b0; ballX = '0; ballY = '0; paddle1Y = '0; paddle2Y = '0; ballBlink = 1'b0;

    // Power-up: no shadow loaded, nothing but net/background may appear
    applyReset(3);
    x = 10'd5; y = 10'd5; activeIn = 1'b1;
    repeat (4) applyStimulus();
    probe("powerup_no_shadow", 5, 5, 1'b1, 12'h000);

    // Latency and sync delay
    ballX = 10'd100; ballY = 10'd200; paddle1Y = 10'd400; paddle2Y = 10'd400;
    frameTick();
    probe("latency_ball", 105, 205, 1'b1, BALL_RGB);
    probe("latency_miss_right", 110, 205, 1'b1, 12'h000);
    probe("ball_last_pixel", 109, 209, 1'b1, BALL_RGB);
    probe("ball_left_of", 99, 205, 1'b1, 12'h000);
    probe("ball_below", 105, 210, 1'b1, 12'h000);
    for (int i = 0; i < 8; i++) begin
      hsyncIn = i[0]; vsyncIn = i[1]; activeIn = i[2];
      applyStimulus();
    end
    hsyncIn = 1'b0; vsyncIn = 1'b0;

    // Priority and blanking
    ballX = 10'd0; ballY = 10'd20; paddle1Y = 10'd20; paddle2Y = 10'd0;
    frameTick();
    probe("prio_ball_over_p1", 5, 25, 1'b1, BALL_RGB);
    probe("p1_below_ball", 5, 35, 1'b1, PADDLE_RGB);
    probe("p1_corner", 9, 69, 1'b1, PADDLE_RGB);
    probe("p1_past_bottom", 5, 70, 1'b1, 12'h000);
    probe("p2_hit", 635, 25, 1'b1, PADDLE_RGB);
    probe("p2_blanked", 635, 25, 1'b0, 12'h000);
    probe("p2_left_edge", 630, 49, 1'b1, PADDLE_RGB);
    probe("p2_left_of", 629, 25, 1'b1, 12'h000);
    probe("p2_past_bottom", 635, 50, 1'b1, 12'h000);
    probe("p2_right_edge", 639, 0, 1'b1, PADDLE_RGB);
    probe("p2_past_right", 640, 0, 1'b1, 12'h000);

    // Tear-free position capture
    ballX = 10'd100; ballY = 10'd200; paddle1Y = 10'd400; paddle2Y = 10'd400;
    frameTick();
    ballX = 10'd300;
    probe("tear_old_pos", 105, 205, 1'b1, BALL_RGB);
    probe("tear_new_not_yet", 305, 205, 1'b1, 12'h000);
    frameStart = 1'b1; x = 10'd105; y = 10'd205; activeIn = 1'b1;
    applyStimulus();
    frameStart = 1'b0; activeIn = 1'b0;
    applyStimulus();
    checkColor("fs_cycle_uses_old", BALL_RGB);
    probe("tear_new_pos", 305, 205, 1'b1, BALL_RGB);
    probe("tear_old_gone", 105, 205, 1'b1, 12'h000);

    // No wrap at the right edge of the coordinate space, and the net
    ballX = 10'd1020; ballY = 10'd0;
    frameTick();
    probe("nowrap_x2", 2, 5, 1'b1, 12'h000);
    probe("edge_ball_1023", 1023, 5, 1'b1, BALL_RGB);
    probe("edge_ball_1019", 1019, 5, 1'b1, 12'h000);
    probe("net_dash", 319, 5, 1'b1, NET_RGB);
    probe("net_dash_right", 320, 15, 1'b1, NET_RGB);
    probe("net_gap", 319, 20, 1'b1, 12'h000);
    probe("net_right_of", 321, 5, 1'b1, 12'h000);
    probe("net_left_of", 318, 5, 1'b1, 12'h000);
    probe("net_second_dash", 320, 32, 1'b1, NET_RGB);

    // Blink with BLINK_FRAMES=2: frame 1 starts with blink off
    ballX = 10'd100; ballY = 10'd200; ballBlink = 1'b0;
    visPattern = 6'b110011;
    frameTick();
    probe("blink_frame1", 105, 205, 1'b1, visPattern[0] ? BALL_RGB : 12'h000);
    ballBlink = 1'b1;
    for (int f = 2; f <= 6; f++) begin
      frameTick();
      probe($sformatf("blink_frame%0d", f), 105, 205, 1'b1,
            visPattern[f-1] ? BALL_RGB : 12'h000);
    end
    frameTick();
    probe("blink_frame7_hidden", 105, 205, 1'b1, 12'h000);
    ballBlink = 1'b0;
    probe("blink_off_midframe", 105, 205, 1'b1, 12'h000);
    frameTick();
    probe("blink_off_next_frame", 105, 205, 1'b1, BALL_RGB);

    // Reset in the middle of a frame discards the pipeline
    x = 10'd105; y = 10'd205; activeIn = 1'b1; hsyncIn = 1'b1; vsyncIn = 1'b1;
    applyStimulus();
    applyReset(1);
    hsyncIn = 1'b0; vsyncIn = 1'b0;
    probe("after_reset_no_shadow", 105, 205, 1'b1, 12'h000);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int mode;
      if (i == 1000) applyReset(1);
      frameStart = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) ballBlink = ~ballBlink;
      ballX    = CW'($urandom_range(0, 1023));
      ballY    = CW'($urandom_range(0, 479));
      paddle1Y = CW'($urandom_range(0, 479));
      paddle2Y = CW'($urandom_range(0, 479));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          x = CW'(mBx + int'($urandom_range(0, 11)) - 1);
          y = CW'(mBy + int'($urandom_range(0, 11)) - 1);
        end
        1: begin
          if ($urandom_range(0, 1) == 0) begin
            x = CW'($urandom_range(0, 11));
            y = CW'(mP1 + int'($urandom_range(0, 51)) - 1);
          end else begin
            x = CW'($urandom_range(628, 641));
            y = CW'(mP2 + int'($urandom_range(0, 51)) - 1);
          end
        end
        2: begin
          x = CW'($urandom_range(317, 322));
          y = CW'($urandom_range(0, 479));
        end
        default: begin
          x = CW'($urandom_range(0, 1023));
          y = CW'($urandom_range(0, 1023));
        end
      endcase
      activeIn = ($urandom_range(0, 7) != 0);
      hsyncIn  = 1'($urandom_range(0, 1));
      vsyncIn  = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
